// File: rtl/regfile_pkg.sv
// Shared state encoding, default widths and constants for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam logic [RF_DATA_W-1:0] ZEROWORD = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: not-ready / zero-register / enable gating, then write
// bypass over the array word; zero latency, no backpressure.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     ready,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        arr_dat,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                     busy,
  output logic                     rd_busy,
`endif
  output logic [DATA_W-1:0]        rdata
);

  logic              byp_hit;
  logic [DATA_W-1:0] byp_dat;
  logic              is_zero;

  // Ascending scan so the highest-index matching write port supplies the data.
  always_comb begin
    byp_hit = 1'b0;
    byp_dat = DATA_W'(ZEROWORD);
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
        byp_hit = 1'b1;
        byp_dat = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);

  always_comb begin
    rdata = DATA_W'(ZEROWORD);
    if (!ready || is_zero || !re) begin
      rdata = DATA_W'(ZEROWORD);
    end else if (byp_hit) begin
      rdata = byp_dat;
    end else begin
      rdata = arr_dat;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  assign rd_busy = busy & re & ready & ~byp_hit & ~is_zero;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file with clear sequencer; reads combinational, writes land next edge,
// ready=0 while clearing (writes dropped). Optional busy scoreboard: REGFILE_SCOREBOARD_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [NUM_RD-1:0]        rd_busy,
`endif
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              ready_q, ready_nxt;
  logic [NUM_WR-1:0] wr_commit;
  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      ready_q <= ready_nxt;
    end
  end

  // A clear request seen while already clearing does not restart the count.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    ready_nxt   = ready_q;
    case (state)
      RF_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_nxt   = RF_RUN;
          clr_cnt_nxt = '0;
          ready_nxt   = 1'b1;
        end
      end
      RF_RUN: begin
        if (clr_req) begin
          state_nxt   = RF_CLEAR;
          clr_cnt_nxt = '0;
          ready_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt   = RF_CLEAR;
        clr_cnt_nxt = '0;
        ready_nxt   = 1'b0;
      end
    endcase
  end

  assign ready = ready_q;

  always_comb begin
    wr_commit = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_commit[i] = we[i] && (state == RF_RUN) &&
                     !((ZERO_REG != 0) && (waddr[i*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Array has no reset; the clear sequencer owns initialisation. Later ports override.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      regs[clr_cnt] <= DATA_W'(ZEROWORD);
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_commit[i]) begin
          regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy, busy_nxt;

  // Entering CLEAR wipes everything; otherwise write-clears first so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (state == RF_RUN) begin
      if (clr_req) begin
        busy_nxt = '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (wr_commit[i]) busy_nxt[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (sb_set && !((ZERO_REG != 0) && (sb_addr == '0))) busy_nxt[sb_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end
`endif

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [DATA_W-1:0] arr_dat;
    assign arr_dat = regs[raddr[j*ADDR_W +: ADDR_W]];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .ready   (ready_q),
      .re      (re[j]),
      .raddr   (raddr[j*ADDR_W +: ADDR_W]),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .arr_dat (arr_dat),
`ifdef REGFILE_SCOREBOARD_EN
      .busy    (busy[raddr[j*ADDR_W +: ADDR_W]]),
      .rd_busy (rd_busy[j]),
`endif
      .rdata   (rdata[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read, 2 write ports): vector table, clear/reset
// sequences, model-driven random traffic and, with REGFILE_SCOREBOARD_EN, busy tracking.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
`ifdef REGFILE_SCOREBOARD_EN
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [1:0]  rd_busy;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .ready   (ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (re),
    .raddr   (raddr),
`ifdef REGFILE_SCOREBOARD_EN
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .rd_busy (rd_busy),
`endif
    .rdata   (rdata)
  );

  typedef struct {
    string       nm;
    int          port;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t vt [12];

  logic [31:0] mdl [32];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic expect_rd(input string nm, input int port, input logic [31:0] e);
    exp_t x;
    x.nm = nm; x.port = port; x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check(x.nm, rdata[x.port*32 +: 32], x.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    we = w; waddr = {a1, a0}; wdata = {d1, d0};
  endtask

  task automatic set_rd(input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1);
    re = r; raddr = {a1, a0};
  endtask

  task automatic count_clear(input string nm);
    int c;
    for (c = 1; c <= 40; c++) begin
      step();
      if (ready) break;
    end
    check(nm, c, 32);
  endtask

  function automatic logic [31:0] mdl_rd(input logic r, input logic [4:0] ra);
    logic [31:0] v;
    if (!r || ra == 5'd0) return '0;
    v = mdl[ra];
    for (int i = 0; i < 2; i++)
      if (we[i] && waddr[i*5 +: 5] == ra) v = wdata[i*32 +: 32];
    return v;
  endfunction

  initial begin
    int done_c;
    logic [1:0] rw, rr;
    logic [4:0] a0, a1, b0, b1;
    logic [31:0] d0, d1;

    rst = 1'b1; clr_req = 1'b0;
    set_wr(2'b00, 0, 0, 0, 0);
    set_rd(2'b00, 0, 0);
`ifdef REGFILE_SCOREBOARD_EN
    sb_set = 1'b0; sb_addr = '0;
`endif
    #2 rst = 1'b0;

    // Power-up clear
    step(); step();
    check("rst_ready", ready, 0);
    @(negedge clk) rst = 1'b1;
    #1 set_rd(2'b01, 5, 0);
    expect_rd("clear_rd_zero", 0, 0);
    #1 drain();
    count_clear("powerup_clear_len");
    expect_rd("reg5_after_clear", 0, 0);
    #2 drain();

    vt[0]  = '{2'b01, 5'd3,  5'd0, 32'hDEADBEEF, 32'h0,        2'b11, 5'd3,  5'd5,  32'hDEADBEEF, 32'h0};
    vt[1]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b01, 5'd3,  5'd3,  32'hDEADBEEF, 32'h0};
    vt[2]  = '{2'b01, 5'd0,  5'd0, 32'h1234,     32'h0,        2'b11, 5'd0,  5'd0,  32'h0,        32'h0};
    vt[3]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b11, 5'd0,  5'd3,  32'h0,        32'hDEADBEEF};
    vt[4]  = '{2'b11, 5'd7,  5'd7, 32'h11,       32'h22,       2'b11, 5'd7,  5'd3,  32'h22,       32'hDEADBEEF};
    vt[5]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b11, 5'd7,  5'd7,  32'h22,       32'h22};
    vt[6]  = '{2'b11, 5'd8,  5'd9, 32'hAAAA,     32'h5A,       2'b11, 5'd8,  5'd9,  32'hAAAA,     32'h5A};
    vt[7]  = '{2'b10, 5'd0,  5'd3, 32'h0,        32'hCAFE,     2'b11, 5'd3,  5'd8,  32'hCAFE,     32'hAAAA};
    vt[8]  = '{2'b01, 5'd3,  5'd0, 32'h77,       32'h0,        2'b11, 5'd3,  5'd9,  32'h77,       32'h5A};
    vt[9]  = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b11, 5'd3,  5'd31, 32'h77,       32'h0};
    vt[10] = '{2'b01, 5'd31, 5'd0, 32'hFFFFFFFF, 32'h0,        2'b10, 5'd31, 5'd31, 32'h0,        32'hFFFFFFFF};
    vt[11] = '{2'b00, 5'd0,  5'd0, 32'h0,        32'h0,        2'b11, 5'd31, 5'd9,  32'hFFFFFFFF, 32'h5A};

    for (int v = 0; v < 12; v++) begin
      set_wr(vt[v].we, vt[v].wa0, vt[v].wa1, vt[v].wd0, vt[v].wd1);
      set_rd(vt[v].re, vt[v].ra0, vt[v].ra1);
      expect_rd($sformatf("vec%0d_p0", v), 0, vt[v].e0);
      expect_rd($sformatf("vec%0d_p1", v), 1, vt[v].e1);
      #3 drain();
      step();
    end
    set_wr(2'b00, 0, 0, 0, 0);

    // Clear request; a second request mid-clear must not extend it, writes are dropped
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_ready_drop", ready, 0);
    done_c = 41;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) clr_req = 1'b1;
      if (c == 20) begin
        set_wr(2'b01, 12, 0, 32'h99, 0);
        set_rd(2'b11, 9, 12);
        expect_rd("clr_rd_zero", 0, 0);
        expect_rd("clr_byp_zero", 1, 0);
        #3 drain();
      end
      step();
      clr_req = 1'b0;
      set_wr(2'b00, 0, 0, 0, 0);
      if (ready) begin
        done_c = c;
        break;
      end
    end
    check("clr_len_no_extend", done_c, 32);
    set_rd(2'b11, 9, 12);
    expect_rd("reg9_cleared", 0, 0);
    expect_rd("reg12_write_dropped", 1, 0);
    #3 drain();

    // Reset in the middle of a clear restarts the full sequence
    set_wr(2'b01, 20, 0, 32'h55, 0);
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 17; c++) step();
    rst = 1'b0;
    #1 check("midclr_rst_ready", ready, 0);
    step(); step();
    check("midclr_rst_hold", ready, 0);
    @(negedge clk) rst = 1'b1;
    count_clear("midclr_restart_len");
    set_rd(2'b01, 20, 0);
    expect_rd("reg20_cleared", 0, 0);
    #3 drain();

    // Random traffic against a behavioural model (array is all-zero here)
    for (int k = 0; k < 32; k++) mdl[k] = '0;
    for (int n = 0; n < 60; n++) begin
      rw = 2'($urandom_range(0, 3));
      rr = 2'($urandom_range(0, 3));
      a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
      b0 = 5'($urandom_range(0, 7)); b1 = 5'($urandom_range(0, 7));
      d0 = $urandom; d1 = $urandom;
      set_wr(rw, a0, a1, d0, d1);
      set_rd(rr, b0, b1);
      expect_rd($sformatf("rnd%0d_p0", n), 0, mdl_rd(rr[0], b0));
      expect_rd($sformatf("rnd%0d_p1", n), 1, mdl_rd(rr[1], b1));
      #3 drain();
      for (int i = 0; i < 2; i++)
        if (we[i] && waddr[i*5 +: 5] != 5'd0) mdl[waddr[i*5 +: 5]] = wdata[i*32 +: 32];
      step();
    end
    set_wr(2'b00, 0, 0, 0, 0);

`ifdef REGFILE_SCOREBOARD_EN
    sb_set = 1'b1; sb_addr = 5'd4;
    step();
    sb_set = 1'b0;
    set_rd(2'b11, 4, 5);
    #3 check("sb_busy_set", rd_busy[0], 1);
    check("sb_other_idle", rd_busy[1], 0);
    set_wr(2'b01, 4, 0, 32'h1, 0);
    expect_rd("sb_byp_data", 0, 32'h1);
    #1 check("sb_byp_not_busy", rd_busy[0], 0);
    drain();
    step();
    set_wr(2'b00, 0, 0, 0, 0);
    #3 check("sb_write_cleared", rd_busy[0], 0);
    sb_set = 1'b1; sb_addr = 5'd4;
    set_wr(2'b01, 4, 0, 32'h2, 0);
    step();
    sb_set = 1'b0;
    set_wr(2'b00, 0, 0, 0, 0);
    #3 check("sb_set_wins", rd_busy[0], 1);
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    sb_set = 1'b0;
    set_rd(2'b01, 0, 4);
    #3 check("sb_zero_never_busy", rd_busy[0], 0);
    check("sb_re_gate", rd_busy[1], 0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    set_rd(2'b11, 4, 4);
    #3 check("sb_clear_gate", rd_busy, 0);
    count_clear("sb_clear_len");
    #3 check("sb_cleared_on_clear", rd_busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
